// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the processor bus arbiter and the BIU.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_FCU = 0;
  localparam int REQ_EU  = 1;
  localparam int REQ_DEC = 2;

  localparam int ARB_NREQ        = 3;
  localparam int SEL_W_DEFAULT   = 2;
  localparam int TIMEOUT_DEFAULT = 15;

  // sel_biu operation codes understood by the BIU
  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_FETCH = 2'b01;
  localparam logic [1:0] SEL_READ  = 2'b10;
  localparam logic [1:0] SEL_WRITE = 2'b11;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping modulo NREQ, wins.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  int v_best;
  int v_dist;

  // Smallest cyclic distance from the pointer wins; no variable bit-selects needed.
  always_comb begin
    o_idx    = '0;
    o_onehot = '0;
    v_best   = NREQ;
    v_dist   = 0;
    for (int j = 0; j < NREQ; j++) begin
      v_dist = j - int'(i_ptr);
      if (v_dist < 0) v_dist = v_dist + NREQ;
      if (i_req[j] && (v_dist < v_best)) begin
        v_best      = v_dist;
        o_idx       = IDX_W'(j);
        o_onehot    = '0;
        o_onehot[j] = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared 16-bit processor bus: grants one requester,
// drives the BIU chip select, and releases on ready_bus or watchdog abort.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int SEL_W   = SEL_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*SEL_W-1:0] req_op,
  input  logic                  ready_bus,
  output logic                  cs_biu,
  output logic [SEL_W-1:0]      sel_biu,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win_idx;
  logic [CNT_W-1:0] r_count;
  logic             r_cs;
  logic [SEL_W-1:0] r_sel;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;
  logic             r_timeout_err;

  logic             w_valid;
  logic [NREQ-1:0]  w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic [SEL_W-1:0] w_ops [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
    assign w_ops[gi] = req_op[gi*SEL_W +: SEL_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_valid  (w_valid),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_win_idx     <= '0;
      r_count       <= '0;
      r_cs          <= 1'b0;
      r_sel         <= SEL_W'(SEL_IDLE);
      r_gnt         <= '0;
      r_done        <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state   <= ST_BUSY;
            r_win_idx <= w_idx;
            r_gnt     <= w_onehot;
            r_cs      <= 1'b1;
            r_sel     <= w_ops[w_idx];
            r_busy    <= 1'b1;
            r_count   <= '0;
          end
        end
        ST_BUSY: begin
          // A ready_bus on the last watchdog cycle counts as a clean completion.
          if (ready_bus || (r_count == CNT_LAST)) begin
            r_state <= ST_RELEASE;
            r_done  <= r_gnt;
            r_gnt   <= '0;
            r_cs    <= 1'b0;
            r_sel   <= SEL_W'(SEL_IDLE);
            r_ptr   <= IDX_W'(rr_next(int'(r_win_idx), NREQ));
            if (!ready_bus) r_timeout_err <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_cs    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cs_biu      = r_cs;
  assign sel_biu     = r_sel;
  assign gnt         = r_gnt;
  assign done        = r_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scenario tasks plus a randomized run checked against a transaction-level
// model of the bus arbiter.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NREQ    = 3;
  localparam int SEL_W   = 2;
  localparam int TIMEOUT = 15;
  localparam int OPW     = NREQ * SEL_W;
  localparam int VW      = 1 + SEL_W + NREQ + NREQ + 1 + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [OPW-1:0]  req_op = '0;
  logic            ready_bus = 1'b0;
  logic            cs_biu;
  logic [SEL_W-1:0] sel_biu;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            busy;
  logic            timeout_err;
  logic [VW-1:0]   dut_vec;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NREQ    (NREQ),
    .SEL_W   (SEL_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_op      (req_op),
    .ready_bus   (ready_bus),
    .cs_biu      (cs_biu),
    .sel_biu     (sel_biu),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  assign dut_vec = {cs_biu, sel_biu, gnt, done, busy, timeout_err};

  // Transaction-level model: who owns the bus, how long it has held it,
  // whether the turnaround cycle is pending, and the rotating priority.
  bit              m_active;
  bit              m_turn;
  bit              m_err;
  int              m_owner;
  int              m_elapsed;
  int              m_ptr;
  logic [SEL_W-1:0] m_sel;
  logic [NREQ-1:0] m_done;
  int              m_wait [NREQ];
  bit              m_grant_evt;
  int              m_worst_wait;

  task automatic model_step(input logic s_rst, input logic [NREQ-1:0] s_req,
                            input logic [OPW-1:0] s_op, input logic s_rdy);
    m_grant_evt = 1'b0;
    if (s_rst) begin
      m_active = 0; m_turn = 0; m_err = 0; m_owner = 0; m_elapsed = 0;
      m_ptr = 0; m_sel = '0; m_done = '0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
    end else begin
      m_done = '0;
      for (int i = 0; i < NREQ; i++) if (!s_req[i]) m_wait[i] = 0;
      if (m_turn) begin
        m_turn = 0;
      end else if (m_active) begin
        m_elapsed++;
        if (s_rdy || m_elapsed == TIMEOUT) begin
          if (!s_rdy) m_err = 1;
          m_done   = NREQ'(1) << m_owner;
          m_ptr    = (m_owner + 1) % NREQ;
          m_active = 0;
          m_turn   = 1;
          m_sel    = '0;
        end
      end else if (s_req != '0) begin
        for (int k = 0; k < NREQ; k++) begin
          int cand;
          cand = (m_ptr + k) % NREQ;
          if (s_req[cand]) begin
            m_owner = cand;
            break;
          end
        end
        m_sel        = SEL_W'(s_op >> (SEL_W * m_owner));
        m_active     = 1;
        m_elapsed    = 0;
        m_grant_evt  = 1;
        m_worst_wait = 0;
        for (int i = 0; i < NREQ; i++) begin
          if (i == m_owner) m_wait[i] = 0;
          else if (s_req[i]) m_wait[i]++;
          if (m_wait[i] > m_worst_wait) m_worst_wait = m_wait[i];
        end
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [NREQ-1:0] g;
    logic [SEL_W-1:0] s;
    g = m_active ? (NREQ'(1) << m_owner) : '0;
    s = m_active ? m_sel : '0;
    return {m_active, s, g, m_done, (m_active || m_turn), m_err};
  endfunction

  task automatic tick();
    logic            s_rst;
    logic [NREQ-1:0] s_req;
    logic [OPW-1:0]  s_op;
    logic            s_rdy;
    s_rst = reset; s_req = req; s_op = req_op; s_rdy = ready_bus;
    @(posedge clk);
    model_step(s_rst, s_req, s_op, s_rdy);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; ready_bus = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; ready_bus = 1'b0;
    tick(); tick();
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", dut_vec);
    end
    reset = 1'b0; ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    n_checks++;
    if ({cs_biu, gnt, done, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_idle_ready: got cs=%b gnt=%b done=%b busy=%b expected all 0",
               cs_biu, gnt, done, busy);
    end
    $display("txn reset complete");
  endtask

  task automatic test_single_fcu();
    req = 3'b001; req_op = OPW'(SEL_FETCH);
    tick();
    req = '0;
    n_checks++;
    if ({gnt, cs_biu, sel_biu, busy} !== {3'b001, 1'b1, SEL_FETCH, 1'b1}) begin
      n_errors++;
      $display("FAIL fcu_grant: got gnt=%b cs=%b sel=%b busy=%b expected 001 1 01 1",
               gnt, cs_biu, sel_biu, busy);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks++;
      if ({gnt, cs_biu, sel_biu, done} !== {3'b001, 1'b1, SEL_FETCH, 3'b000}) begin
        n_errors++;
        $display("FAIL fcu_hold[%0d]: got gnt=%b cs=%b sel=%b done=%b expected 001 1 01 000",
                 k, gnt, cs_biu, sel_biu, done);
      end
    end
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    n_checks++;
    if ({done, cs_biu, gnt, busy} !== {3'b001, 1'b0, 3'b000, 1'b1}) begin
      n_errors++;
      $display("FAIL fcu_done: got done=%b cs=%b gnt=%b busy=%b expected 001 0 000 1",
               done, cs_biu, gnt, busy);
    end
    tick();
    n_checks++;
    if ({done, busy, cs_biu} !== '0) begin
      n_errors++;
      $display("FAIL fcu_idle: got done=%b busy=%b cs=%b expected 000 0 0", done, busy, cs_biu);
    end
    $display("txn fcu single transfer");
  endtask

  task automatic test_spurious_withdrawn();
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    n_checks++;
    if ({done, cs_biu, busy, gnt} !== '0) begin
      n_errors++;
      $display("FAIL spurious_ready: got done=%b cs=%b busy=%b gnt=%b expected 0",
               done, cs_biu, busy, gnt);
    end
    req = 3'b100; req_op = {SEL_WRITE, SEL_IDLE, SEL_IDLE};
    tick();
    req = '0;
    tick(); tick();
    n_checks++;
    if ({cs_biu, gnt, sel_biu} !== {1'b1, 3'b100, SEL_WRITE}) begin
      n_errors++;
      $display("FAIL withdrawn_hold: got cs=%b gnt=%b sel=%b expected 1 100 11",
               cs_biu, gnt, sel_biu);
    end
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    n_checks++;
    if (done !== 3'b100) begin
      n_errors++;
      $display("FAIL withdrawn_done: got done=%b expected 100", done);
    end
    tick(); tick();
    $display("txn decoder withdrawn request completed");
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_order [4];
    exp_order[0] = 3'b001; exp_order[1] = 3'b010;
    exp_order[2] = 3'b100; exp_order[3] = 3'b001;
    do_reset();
    req = 3'b111; req_op = OPW'($urandom);
    for (int g = 0; g < 4; g++) begin
      int gap;
      gap = 0;
      while (!cs_biu && gap < 10) begin
        tick();
        gap++;
      end
      n_checks++;
      if (cs_biu !== 1'b1 || gnt !== exp_order[g]) begin
        n_errors++;
        $display("FAIL rr_grant[%0d]: got cs=%b gnt=%b expected 1 %b", g, cs_biu, gnt, exp_order[g]);
      end
      if (g > 0) begin
        n_checks++;
        if (gap != 2) begin
          n_errors++;
          $display("FAIL rr_gap[%0d]: got %0d idle cycles expected 2", g, gap);
        end
      end
      tick();
      ready_bus = 1'b1;
      tick();
      ready_bus = 1'b0;
      n_checks++;
      if (done !== exp_order[g] || cs_biu !== 1'b0) begin
        n_errors++;
        $display("FAIL rr_done[%0d]: got done=%b cs=%b expected %b 0", g, done, cs_biu, exp_order[g]);
      end
      $display("txn rr grant %0d done=%b", g, done);
    end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_race();
    do_reset();
    req = 3'b001; req_op = OPW'(SEL_READ);
    tick();
    req = '0;
    for (int k = 1; k < TIMEOUT; k++) tick();
    n_checks++;
    if (cs_biu !== 1'b1) begin
      n_errors++;
      $display("FAIL race_hold: got cs=%b expected 1", cs_biu);
    end
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    n_checks++;
    if ({done, cs_biu, timeout_err} !== {3'b001, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL race_done: got done=%b cs=%b err=%b expected 001 0 0", done, cs_biu, timeout_err);
    end
    tick(); tick();
    $display("txn ready on watchdog cycle");
  endtask

  task automatic test_timeout();
    int high;
    req = 3'b010; req_op = {SEL_IDLE, SEL_READ, SEL_IDLE}; ready_bus = 1'b0;
    tick();
    req = '0;
    high = cs_biu ? 1 : 0;
    while (cs_biu && high < 300) begin
      tick();
      if (cs_biu) high++;
    end
    n_checks++;
    if (high != TIMEOUT) begin
      n_errors++;
      $display("FAIL timeout_len: got %0d cs cycles expected %0d", high, TIMEOUT);
    end
    n_checks++;
    if ({done, timeout_err} !== {3'b010, 1'b1}) begin
      n_errors++;
      $display("FAIL timeout_abort: got done=%b err=%b expected 010 1", done, timeout_err);
    end
    tick(); tick();
    req = 3'b001;
    tick();
    req = '0;
    tick();
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    tick(); tick();
    n_checks++;
    if (timeout_err !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_sticky: got err=%b expected 1", timeout_err);
    end
    $display("txn watchdog abort on eu");
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req = 3'b010;
    tick();
    req = '0;
    tick();
    ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    tick(); tick();
    req = 3'b010;
    tick();
    req = '0;
    tick();
    reset = 1'b1; req = 3'b110;
    tick();
    n_checks++;
    if (dut_vec !== '0) begin
      n_errors++;
      $display("FAIL midbusy_reset: got %h expected 0", dut_vec);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 3'b010) begin
      n_errors++;
      $display("FAIL midbusy_ptr: got gnt=%b expected 010", gnt);
    end
    req = '0; ready_bus = 1'b1;
    tick();
    ready_bus = 1'b0;
    tick(); tick();
    $display("txn reset during eu transfer");
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 7));
      req_op    = OPW'($urandom);
      ready_bus = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++;
      if (dut_vec !== model_vec()) begin
        n_errors++;
        $display("FAIL random[%0d]: got {cs,sel,gnt,done,busy,err}=%b expected %b",
                 c, dut_vec, model_vec());
      end
      if (m_grant_evt) begin
        n_checks++;
        if (m_worst_wait > NREQ - 1) begin
          n_errors++;
          $display("FAIL fairness[%0d]: got wait %0d expected <= %0d", c, m_worst_wait, NREQ - 1);
        end
      end
      if (m_done != '0) $display("txn random cycle %0d done=%b err=%0b", c, m_done, m_err);
    end
    reset = 1'b0; req = '0; ready_bus = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fcu();
    test_spurious_withdrawn();
    test_round_robin();
    test_race();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got no finish expected finish before 1000000");
    $fatal(1, "time limit");
  end

endmodule
